step_counter: RTL
=================

STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the step count register.
REQ-002 Parameter MIN_GAP, default 8, is the number of valid samples ignored after a step ends; legal range is 1 to 255.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset.
REQ-005 step_in  input  1  is the boolean step decision from the execution-block activation stage.
REQ-006 sample_valid  input  1  qualifies step_in as a new classified sample for this cycle.
REQ-007 cmd_valid  input  1  qualifies funct for this cycle.
REQ-008 funct  input  3  is the instruction code: 0 = reset count, 1 = normal counting, 2 = update weights (counting suspended), 3 to 7 = no effect.
REQ-009 rd_req  input  1  is a count read request.
REQ-010 step_count  output  CNT_W  is the live step count.
REQ-011 step_pulse  output  1  is a one-cycle strobe marking an accepted step.
REQ-012 sat  output  1  is a sticky flag meaning a step was lost because the count was at maximum.
REQ-013 counting  output  1  reflects the enable register.
REQ-014 rd_valid  output  1  is a one-cycle read acknowledge.
REQ-015 rd_data  output  CNT_W  is the read snapshot, valid when rd_valid=1.

Function
REQ-016 The enable register SHALL be set by cmd_valid with funct=1, and cleared by cmd_valid with funct=0 or funct=2.
REQ-017 cmd_valid with funct=0 SHALL clear step_count, sat and the gap counter, and force the FSM to IDLE, all in the next cycle.
REQ-018 The FSM SHALL have exactly three states: IDLE, HIGH and REFRACT.
REQ-019 In IDLE, enable=1 with sample_valid=1 and step_in=1 SHALL accept a step and transition to HIGH.
REQ-020 In HIGH, sample_valid=1 with step_in=0 SHALL transition to REFRACT and load the gap counter with MIN_GAP.
REQ-021 In HIGH, samples with step_in=1 SHALL NOT be counted.
REQ-022 In REFRACT, each sample_valid SHALL decrement the gap counter regardless of step_in.
REQ-023 The sample that takes the gap counter from 1 to 0 SHALL transition the FSM to IDLE; that sample SHALL NOT be counted.
REQ-024 Cycles with sample_valid=0 SHALL leave the FSM state and the gap counter unchanged.
REQ-025 When enable=0, the FSM SHALL go to IDLE in the next cycle and SHALL accept no steps.
REQ-026 An accepted step with step_count below 2^CNT_W-1 SHALL increment step_count by 1 and assert step_pulse for one cycle; both take effect in the cycle after the accepting sample.
REQ-027 An accepted step with step_count at 2^CNT_W-1 SHALL hold step_count, set sat, and not assert step_pulse.
REQ-028 rd_req SHALL produce rd_valid=1 in the next cycle, with rd_data equal to step_count as it stood in the request cycle.
REQ-029 Back-to-back rd_req SHALL produce back-to-back rd_valid; there is no backpressure.
REQ-030 rd_data SHALL hold its last value while rd_valid=0.
REQ-031 When a funct=0 command and an accepted step occur in the same cycle, the clear SHALL win: step_count becomes 0 and step_pulse stays 0.
REQ-032 When a funct=0 command and rd_req occur in the same cycle, rd_data SHALL return the pre-clear value.
REQ-033 When a funct=1 command and a qualifying sample occur in the same cycle, the sample SHALL NOT be counted, because enable takes effect in the following cycle.

Reset
REQ-034 In any cycle with rst=1, the block SHALL next-cycle drive step_count=0, step_pulse=0, sat=0, counting=0, rd_valid=0, rd_data=0, FSM=IDLE and gap counter=0.
REQ-035 rst SHALL override cmd_valid, sample_valid and rd_req in the same cycle, including when asserted mid-step (HIGH) or mid-refractory (REFRACT).

Verification
REQ-036 Counting scenario: funct=1, then the valid step_in sequence 1,1,0 followed by 8 samples of 0, then 1 -> step_count goes 0 to 1 to 2, with exactly two step_pulse strobes.
REQ-037 Refractory scenario: MIN_GAP=8; a step_in=1 sample arriving on the 4th sample of REFRACT, then 1 on the 9th sample after the falling edge -> the first is ignored and the second is counted.
REQ-038 Saturation scenario: CNT_W=4, preload 15 steps, then one more step -> step_count=15, sat=1, no step_pulse.
REQ-039 Clear race scenario: funct=0 with an accepted step and rd_req, all in the same cycle, while count=5 -> step_count=0, step_pulse=0, rd_data=5 in the next cycle.
REQ-040 Suspend scenario: funct=2 while in HIGH, then step_in pulses -> FSM goes to IDLE, count is frozen and counting=0; a later funct=1 resumes counting.
REQ-041 Reset scenario: rst asserted in REFRACT with count=3 and sat=1 -> all outputs are 0 in the next cycle, and the first valid step after funct=1 gives count=1.

Source files
------------

// File: rtl/step_counter.sv
// step_counter
//
// Counts accepted steps from a stream of classified samples.
//
// After a step is accepted, the counter waits for the step to end. A step
// ends on a valid sample with step_in=0. The counter then ignores a fixed
// number of further valid samples (the refractory gap). This stops one
// physical step from being counted more than once. Counting is turned on
// and off through a small command interface, and the count can be read
// as a registered snapshot.
//
// Parameters:
//   CNT_W    width of the step count register
//   MIN_GAP  valid samples ignored after a step ends (1..255)
//
// Ports:
//   clk           single clock, rising-edge
//   rst           synchronous active-high reset
//   step_in       boolean step decision for the current sample
//   sample_valid  step_in carries a new classified sample this cycle
//   cmd_valid     funct is valid this cycle
//   funct         0 = clear count, 1 = count, 2 = suspend (weight update),
//                 3..7 = no effect
//   rd_req        request a snapshot of the count
//   step_count    live step count
//   step_pulse    one-cycle strobe for each counted step
//   sat           sticky: a step was lost because the count was full
//   counting      current state of the enable register
//   rd_valid      one-cycle acknowledge for rd_req
//   rd_data       count snapshot, held between reads

module step_counter #(
  parameter int CNT_W   = 16,
  parameter int MIN_GAP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             sample_valid,
  input  logic             cmd_valid,
  input  logic [2:0]       funct,
  input  logic             rd_req,
  output logic [CNT_W-1:0] step_count,
  output logic             step_pulse,
  output logic             sat,
  output logic             counting,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    REFRACT = 2'd2
  } state_t;

  localparam logic [7:0]       GAP_LOAD = 8'(MIN_GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [7:0]       gap_cnt, gap_nxt;
  logic             enable, enable_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             pulse_nxt, sat_nxt;
  logic             clear_cmd;
  logic             accept;

  assign clear_cmd = cmd_valid && (funct == 3'd0);
  assign counting  = enable;

  // A command updates the enable register for the following cycle.
  // Because of that one-cycle delay, a sample that arrives together
  // with the "count" command is not yet counted.
  always_comb begin
    enable_nxt = enable;
    if (cmd_valid) begin
      if (funct == 3'd1)
        enable_nxt = 1'b1;
      else if ((funct == 3'd0) || (funct == 3'd2))
        enable_nxt = 1'b0;
    end
  end

  // Step detector FSM.
  // A clear command, or counting being disabled, forces IDLE. This
  // discards any step that is still in progress. Cycles without a valid
  // sample leave the state and the gap counter unchanged.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    accept    = 1'b0;
    if (clear_cmd || !enable) begin
      state_nxt = IDLE;
      gap_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid && step_in) begin
            accept    = 1'b1;
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (sample_valid && !step_in) begin
            state_nxt = REFRACT;
            gap_nxt   = GAP_LOAD;
          end
        end
        REFRACT: begin
          // The sample that empties the gap only closes the refractory
          // window. It is never counted as a step.
          if (sample_valid) begin
            if (gap_cnt <= 8'd1) begin
              gap_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              gap_nxt = gap_cnt - 8'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          gap_nxt   = '0;
        end
      endcase
    end
  end

  // Count update.
  // accept is never set during a clear, so a clear always wins against
  // a step in the same cycle. At full scale the step is dropped and
  // recorded in sat instead of wrapping the count.
  always_comb begin
    count_nxt = step_count;
    pulse_nxt = 1'b0;
    sat_nxt   = sat;
    if (clear_cmd) begin
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end else if (accept) begin
      if (step_count == CNT_MAX) begin
        sat_nxt = 1'b1;
      end else begin
        count_nxt = step_count + 1'b1;
        pulse_nxt = 1'b1;
      end
    end
  end

  // State registers.
  // The read snapshot takes step_count before this cycle's update. A
  // read issued together with a clear therefore returns the old count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      enable     <= 1'b0;
      step_count <= '0;
      step_pulse <= 1'b0;
      sat        <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      enable     <= enable_nxt;
      step_count <= count_nxt;
      step_pulse <= pulse_nxt;
      sat        <= sat_nxt;
      rd_valid   <= rd_req;
      if (rd_req)
        rd_data <= step_count;
    end
  end

endmodule
